// File: rtl/instruction_fetch.sv
// MIPS fetch unit: PC register, synchronous capture of the combinational imem word, small {pc,instr} FIFO to decode.
// One-cycle fetch-to-head latency; a redirect flushes the FIFO and reloads the PC (word-aligned).
module instruction_fetch #(
   parameter int PC_WIDTH    = 8,
   parameter int INSTR_WIDTH = 32,
   parameter int RESET_PC    = 0,
   parameter int DEPTH       = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fetch_en,
   output logic [PC_WIDTH-1:0]    imem_pc,
   input  logic [INSTR_WIDTH-1:0] imem_instr,
   input  logic                   redirect_valid,
   input  logic [PC_WIDTH-1:0]    redirect_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INSTR_WIDTH-1:0] out_instr,
   output logic [PC_WIDTH-1:0]    out_pc
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]          count_q, count_d;
   logic [PC_WIDTH-1:0]    pc_mem_q    [DEPTH];
   logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];
   logic                   pop;
   logic                   push;

   assign pop  = out_valid & out_ready;
   // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
   assign push = fetch_en & ~redirect_valid & ((count_q < CW'(DEPTH)) | pop);

   assign imem_pc   = pc_q;
   assign out_valid = (count_q != '0);
   assign out_instr = instr_mem_q[rd_ptr_q];
   assign out_pc    = pc_mem_q[rd_ptr_q];

   always_comb begin
      pc_d     = pc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (redirect_valid) begin
         pc_d     = redirect_pc & ~PC_WIDTH'(3);
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            pc_d     = pc_q + PC_WIDTH'(4);
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q     <= PC_WIDTH'(RESET_PC);
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         pc_q     <= pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else if (push) begin
         pc_mem_q[wr_ptr_q]    <= imem_pc;
         instr_mem_q[wr_ptr_q] <= imem_instr;
      end
   end

endmodule
